// File: rtl/pdp8_trace_buffer.sv
// Trace capture for the PDP-8 core: memory and branch events merged into one
// circular record buffer, read out first-word-fall-through over valid/ready.
module pdp8_trace_buffer #(
   parameter int unsigned DEPTH     = 64,
   parameter int unsigned AW        = 12,
   parameter int unsigned DW        = 12,
   parameter int unsigned WRAP_MODE = 1,
   parameter int unsigned DROP_W    = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic                      freeze,
   input  logic                      clear,
   input  logic                      mem_valid,
   input  logic                      mem_write,
   input  logic                      mem_ifetch,
   input  logic [AW-1:0]             mem_addr,
   input  logic [DW-1:0]             mem_data,
   input  logic                      br_valid,
   input  logic [1:0]                br_kind,
   input  logic                      br_taken,
   input  logic [AW-1:0]             br_pc,
   input  logic [AW-1:0]             br_target,
   output logic                      rd_valid,
   input  logic                      rd_ready,
   output logic [3+AW+DW-1:0]        rd_data,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      overflow,
   output logic [DROP_W-1:0]         drop_count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned RW = 3 + AW + DW;

   localparam logic [2:0] T_IF     = 3'd0;
   localparam logic [2:0] T_DR     = 3'd1;
   localparam logic [2:0] T_DW     = 3'd2;
   localparam logic [2:0] T_BR_SUB = 3'd3;
   localparam logic [2:0] T_BR_UNC = 3'd4;
   localparam logic [2:0] T_BR_CT  = 3'd5;
   localparam logic [2:0] T_BR_CNT = 3'd6;

   function automatic logic [2:0] mem_type(input logic wr, input logic ifetch);
      logic [2:0] t;
      if (wr) begin
         t = T_DW;
      end else if (ifetch) begin
         t = T_IF;
      end else begin
         t = T_DR;
      end
      return t;
   endfunction

   // Kind 3 is unused by the core; it is recorded as an unconditional branch.
   function automatic logic [2:0] br_type(input logic [1:0] kind, input logic taken);
      logic [2:0] t;
      case (kind)
         2'd0:    t = T_BR_SUB;
         2'd1:    t = T_BR_UNC;
         2'd2:    t = taken ? T_BR_CT : T_BR_CNT;
         default: t = T_BR_UNC;
      endcase
      return t;
   endfunction

   function automatic logic [DW-1:0] fit_data(input logic [AW-1:0] a);
      logic [AW+DW-1:0] wide;
      wide = {{DW{1'b0}}, a};
      return wide[DW-1:0];
   endfunction

   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              overflow_q, overflow_d;
   logic [DROP_W-1:0] drop_q, drop_d;
   logic              skid_v_q, skid_v_d;
   logic [RW-1:0]     skid_q, skid_d;
   logic              rd_valid_q, rd_valid_d;
   logic [RW-1:0]     rd_data_q, rd_data_d;
   logic [RW-1:0]     mem_q [DEPTH];

   logic              cap_s, mem_ev_s, br_ev_s;
   logic [RW-1:0]     mem_rec_s, br_rec_s;
   logic              src_v_s;
   logic [RW-1:0]     src_rec_s;
   logic              skid_drop_s, buf_drop_s;
   logic              full_s, pop_s, wr_en_s;
   logic [1:0]        drop_inc_s;
   logic [DROP_W+1:0] drop_sum_s;

   // Event qualification and write-source arbitration (memory, then skid, then branch).
   always_comb begin
      cap_s       = enable & ~freeze & ~clear;
      mem_ev_s    = cap_s & mem_valid;
      br_ev_s     = cap_s & br_valid;
      mem_rec_s   = {mem_type(mem_write, mem_ifetch), mem_addr, mem_data};
      br_rec_s    = {br_type(br_kind, br_taken), br_pc, fit_data(br_target)};
      src_v_s     = 1'b0;
      src_rec_s   = {RW{1'b0}};
      skid_v_d    = skid_v_q;
      skid_d      = skid_q;
      skid_drop_s = 1'b0;
      if (mem_ev_s) begin
         src_v_s   = 1'b1;
         src_rec_s = mem_rec_s;
         if (br_ev_s && skid_v_q) begin
            skid_drop_s = 1'b1;
         end else if (br_ev_s) begin
            skid_v_d = 1'b1;
            skid_d   = br_rec_s;
         end else begin
            skid_v_d = skid_v_q;
         end
      end else if (skid_v_q) begin
         // The skid drains even with capture off: its event was already accepted.
         src_v_s   = 1'b1;
         src_rec_s = skid_q;
         if (br_ev_s) begin
            skid_v_d = 1'b1;
            skid_d   = br_rec_s;
         end else begin
            skid_v_d = 1'b0;
         end
      end else if (br_ev_s) begin
         src_v_s   = 1'b1;
         src_rec_s = br_rec_s;
      end else begin
         src_v_s = 1'b0;
      end
      if (clear) begin
         skid_v_d = 1'b0;
      end else begin
         skid_v_d = skid_v_d;
      end
   end

   // Pointer, occupancy, flag and drop-counter next state.
   always_comb begin
      full_s     = (count_q == CW'(DEPTH));
      pop_s      = rd_valid_q & rd_ready;
      wr_en_s    = 1'b0;
      buf_drop_s = 1'b0;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (src_v_s && full_s && !pop_s) begin
         if (WRAP_MODE != 0) begin
            wr_en_s    = 1'b1;
            wr_ptr_d   = wr_ptr_q + PW'(1);
            rd_ptr_d   = rd_ptr_q + PW'(1);
            overflow_d = 1'b1;
         end else begin
            buf_drop_s = 1'b1;
         end
      end else if (src_v_s) begin
         wr_en_s  = 1'b1;
         wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end else begin
            count_d = count_q + CW'(1);
         end
      end else if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
         count_d  = count_q - CW'(1);
      end else begin
         count_d = count_q;
      end

      drop_inc_s = {1'b0, skid_drop_s} + {1'b0, buf_drop_s};
      drop_sum_s = {2'b00, drop_q} + {{DROP_W{1'b0}}, drop_inc_s};
      if (drop_sum_s > {2'b00, {DROP_W{1'b1}}}) begin
         drop_d = {DROP_W{1'b1}};
      end else begin
         drop_d = drop_sum_s[DROP_W-1:0];
      end

      if (clear) begin
         wr_en_s    = 1'b0;
         wr_ptr_d   = {PW{1'b0}};
         rd_ptr_d   = {PW{1'b0}};
         count_d    = {CW{1'b0}};
         overflow_d = 1'b0;
         drop_d     = {DROP_W{1'b0}};
      end else begin
         overflow_d = overflow_d;
      end
   end

   // Head-of-buffer lookahead so rd_data can be a register; a record written
   // this cycle into the slot that becomes the head is forwarded directly.
   always_comb begin
      rd_valid_d = (count_d != {CW{1'b0}});
      if (count_d == {CW{1'b0}}) begin
         rd_data_d = {RW{1'b0}};
      end else if (wr_en_s && (wr_ptr_q == rd_ptr_d)) begin
         rd_data_d = src_rec_s;
      end else begin
         rd_data_d = mem_q[rd_ptr_d];
      end
   end

   // Control state registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= {PW{1'b0}};
         rd_ptr_q   <= {PW{1'b0}};
         count_q    <= {CW{1'b0}};
         overflow_q <= 1'b0;
         drop_q     <= {DROP_W{1'b0}};
         skid_v_q   <= 1'b0;
         skid_q     <= {RW{1'b0}};
         rd_valid_q <= 1'b0;
         rd_data_q  <= {RW{1'b0}};
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         drop_q     <= drop_d;
         skid_v_q   <= skid_v_d;
         skid_q     <= skid_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   // Record storage; contents are only visible through rd_data_q, so no reset.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_q[wr_ptr_q] <= src_rec_s;
      end
   end

   assign rd_valid   = rd_valid_q;
   assign rd_data    = rd_data_q;
   assign count      = count_q;
   assign overflow   = overflow_q;
   assign drop_count = drop_q;

endmodule

// File: tb/tb_pdp8_trace_buffer.sv
// Self-checking bench: three buffer configurations share stimulus; expected
// records are queued as events are driven and compared as they are popped.
module tb_pdp8_trace_buffer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0, freeze = 1'b0, clear = 1'b0;
   logic        mem_valid = 1'b0, mem_write = 1'b0, mem_ifetch = 1'b0;
   logic [11:0] mem_addr = 12'd0, mem_data = 12'd0;
   logic        br_valid = 1'b0, br_taken = 1'b0;
   logic [1:0]  br_kind = 2'd0;
   logic [11:0] br_pc = 12'd0, br_target = 12'd0;
   logic        rd_ready = 1'b0;

   logic        big_rd_valid, w4_rd_valid, d4_rd_valid;
   logic [26:0] big_rd_data, w4_rd_data, d4_rd_data;
   logic [6:0]  big_count;
   logic [2:0]  w4_count, d4_count;
   logic        big_overflow, w4_overflow, d4_overflow;
   logic [7:0]  big_drop, w4_drop, d4_drop;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [26:0] q[$];
   logic [26:0] e;

   always #5 clk = ~clk;

   pdp8_trace_buffer #(.DEPTH(64), .WRAP_MODE(1)) u_big (
      .clk(clk), .reset(reset), .enable(enable), .freeze(freeze), .clear(clear),
      .mem_valid(mem_valid), .mem_write(mem_write), .mem_ifetch(mem_ifetch),
      .mem_addr(mem_addr), .mem_data(mem_data), .br_valid(br_valid), .br_kind(br_kind),
      .br_taken(br_taken), .br_pc(br_pc), .br_target(br_target), .rd_valid(big_rd_valid),
      .rd_ready(rd_ready), .rd_data(big_rd_data), .count(big_count),
      .overflow(big_overflow), .drop_count(big_drop));

   pdp8_trace_buffer #(.DEPTH(4), .WRAP_MODE(1)) u_w4 (
      .clk(clk), .reset(reset), .enable(enable), .freeze(freeze), .clear(clear),
      .mem_valid(mem_valid), .mem_write(mem_write), .mem_ifetch(mem_ifetch),
      .mem_addr(mem_addr), .mem_data(mem_data), .br_valid(br_valid), .br_kind(br_kind),
      .br_taken(br_taken), .br_pc(br_pc), .br_target(br_target), .rd_valid(w4_rd_valid),
      .rd_ready(rd_ready), .rd_data(w4_rd_data), .count(w4_count),
      .overflow(w4_overflow), .drop_count(w4_drop));

   pdp8_trace_buffer #(.DEPTH(4), .WRAP_MODE(0)) u_d4 (
      .clk(clk), .reset(reset), .enable(enable), .freeze(freeze), .clear(clear),
      .mem_valid(mem_valid), .mem_write(mem_write), .mem_ifetch(mem_ifetch),
      .mem_addr(mem_addr), .mem_data(mem_data), .br_valid(br_valid), .br_kind(br_kind),
      .br_taken(br_taken), .br_pc(br_pc), .br_target(br_target), .rd_valid(d4_rd_valid),
      .rd_ready(rd_ready), .rd_data(d4_rd_data), .count(d4_count),
      .overflow(d4_overflow), .drop_count(d4_drop));

   task automatic set_mem(input logic w, input logic f, input logic [11:0] a, input logic [11:0] d);
      mem_valid = 1'b1; mem_write = w; mem_ifetch = f; mem_addr = a; mem_data = d;
   endtask

   task automatic set_br(input logic [1:0] k, input logic t, input logic [11:0] pc, input logic [11:0] tg);
      br_valid = 1'b1; br_kind = k; br_taken = t; br_pc = pc; br_target = tg;
   endtask

   task automatic idle();
      mem_valid = 1'b0; br_valid = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_cmp++; if (big_rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid: got %b want 0", big_rd_valid); end
      n_cmp++; if (big_count !== 7'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", big_count); end
      n_cmp++; if (big_rd_data !== 27'd0) begin n_err++; $display("FAIL reset_rd_data: got %h want 0", big_rd_data); end
      n_cmp++; if (big_overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", big_overflow); end
      n_cmp++; if (big_drop !== 8'd0) begin n_err++; $display("FAIL reset_drop: got %0d want 0", big_drop); end
   endtask

   task automatic test_capture_order();
      q.delete();
      enable = 1'b1;
      set_mem(1'b0, 1'b1, 12'o0200, 12'o7200); q.push_back({3'd0, 12'o0200, 12'o7200});
      @(negedge clk);
      set_mem(1'b0, 1'b0, 12'o0300, 12'o1234); q.push_back({3'd1, 12'o0300, 12'o1234});
      e = {3'd0, 12'o0200, 12'o7200};
      n_cmp++; if (big_rd_data !== e) begin n_err++; $display("FAIL cap_first_latency: got %h want %h", big_rd_data, e); end
      n_cmp++; if (big_rd_valid !== 1'b1) begin n_err++; $display("FAIL cap_rd_valid: got %b want 1", big_rd_valid); end
      @(negedge clk);
      set_mem(1'b1, 1'b0, 12'o0301, 12'o4321); q.push_back({3'd2, 12'o0301, 12'o4321});
      @(negedge clk);
      idle();
      n_cmp++; if (big_count !== 7'd3) begin n_err++; $display("FAIL cap_count: got %0d want 3", big_count); end
      rd_ready = 1'b1;
      for (int n = 0; n < 16 && q.size() != 0; n++) begin
         if (big_rd_valid) begin
            e = q.pop_front();
            n_cmp++; if (big_rd_data !== e) begin n_err++; $display("FAIL cap_record: got %h want %h", big_rd_data, e); end
         end
         @(negedge clk);
      end
      rd_ready = 1'b0;
      n_cmp++; if (q.size() != 0) begin n_err++; $display("FAIL cap_drain_timeout: left %0d want 0", q.size()); end
      n_cmp++; if (big_count !== 7'd0) begin n_err++; $display("FAIL cap_empty_count: got %0d want 0", big_count); end
   endtask

   task automatic test_back_to_back();
      q.delete();
      // same-cycle memory and branch: branch goes through the skid
      set_mem(1'b0, 1'b0, 12'o0100, 12'o5555); set_br(2'd2, 1'b1, 12'o0205, 12'o0207);
      q.push_back({3'd1, 12'o0100, 12'o5555}); q.push_back({3'd5, 12'o0205, 12'o0207});
      @(negedge clk);
      idle();
      n_cmp++; if (big_count !== 7'd1) begin n_err++; $display("FAIL b2b_count1: got %0d want 1", big_count); end
      @(negedge clk);
      n_cmp++; if (big_count !== 7'd2) begin n_err++; $display("FAIL b2b_count2: got %0d want 2", big_count); end
      n_cmp++; if (big_drop !== 8'd0) begin n_err++; $display("FAIL b2b_drop0: got %0d want 0", big_drop); end
      // skid occupied and not draining: second branch is dropped
      set_mem(1'b0, 1'b0, 12'o0400, 12'o0011); set_br(2'd0, 1'b0, 12'o0401, 12'o0500);
      q.push_back({3'd1, 12'o0400, 12'o0011});
      @(negedge clk);
      set_mem(1'b0, 1'b1, 12'o0402, 12'o0022); set_br(2'd1, 1'b0, 12'o0403, 12'o0600);
      q.push_back({3'd0, 12'o0402, 12'o0022}); q.push_back({3'd3, 12'o0401, 12'o0500});
      @(negedge clk);
      idle();
      @(negedge clk);
      n_cmp++; if (big_count !== 7'd5) begin n_err++; $display("FAIL b2b_count5: got %0d want 5", big_count); end
      n_cmp++; if (big_drop !== 8'd1) begin n_err++; $display("FAIL b2b_drop1: got %0d want 1", big_drop); end
      // skid draining while a new branch arrives: new branch refills the skid
      set_mem(1'b1, 1'b0, 12'o0700, 12'o0033); set_br(2'd2, 1'b0, 12'o0701, 12'o0710);
      q.push_back({3'd2, 12'o0700, 12'o0033}); q.push_back({3'd6, 12'o0701, 12'o0710});
      @(negedge clk);
      mem_valid = 1'b0; set_br(2'd1, 1'b0, 12'o0702, 12'o1000);
      q.push_back({3'd4, 12'o0702, 12'o1000});
      @(negedge clk);
      idle();
      @(negedge clk);
      n_cmp++; if (big_count !== 7'd8) begin n_err++; $display("FAIL b2b_count8: got %0d want 8", big_count); end
      n_cmp++; if (big_drop !== 8'd1) begin n_err++; $display("FAIL b2b_drop_hold: got %0d want 1", big_drop); end
      rd_ready = 1'b1;
      for (int n = 0; n < 32 && q.size() != 0; n++) begin
         if (big_rd_valid) begin
            e = q.pop_front();
            n_cmp++; if (big_rd_data !== e) begin n_err++; $display("FAIL b2b_record: got %h want %h", big_rd_data, e); end
         end
         @(negedge clk);
      end
      rd_ready = 1'b0;
      n_cmp++; if (q.size() != 0) begin n_err++; $display("FAIL b2b_drain_timeout: left %0d want 0", q.size()); end
      // clear wins over a coincident event and wipes the drop counter
      set_mem(1'b0, 1'b0, 12'o0001, 12'o0002);
      do_clear();
      idle();
      @(negedge clk);
      n_cmp++; if (big_count !== 7'd0) begin n_err++; $display("FAIL clr_count: got %0d want 0", big_count); end
      n_cmp++; if (big_drop !== 8'd0) begin n_err++; $display("FAIL clr_drop: got %0d want 0", big_drop); end
      n_cmp++; if (big_rd_valid !== 1'b0) begin n_err++; $display("FAIL clr_rd_valid: got %b want 0", big_rd_valid); end
   endtask

   task automatic test_wrap();
      q.delete();
      do_clear();
      for (int i = 1; i <= 6; i++) begin
         set_mem(1'b1, 1'b0, 12'(i), 12'(i * 11));
         if (i >= 3) q.push_back({3'd2, 12'(i), 12'(i * 11)});
         @(negedge clk);
      end
      idle();
      n_cmp++; if (w4_count !== 3'd4) begin n_err++; $display("FAIL wrap_count: got %0d want 4", w4_count); end
      n_cmp++; if (w4_overflow !== 1'b1) begin n_err++; $display("FAIL wrap_overflow: got %b want 1", w4_overflow); end
      n_cmp++; if (w4_drop !== 8'd0) begin n_err++; $display("FAIL wrap_drop: got %0d want 0", w4_drop); end
      rd_ready = 1'b1;
      for (int n = 0; n < 16 && q.size() != 0; n++) begin
         if (w4_rd_valid) begin
            e = q.pop_front();
            n_cmp++; if (w4_rd_data !== e) begin n_err++; $display("FAIL wrap_record: got %h want %h", w4_rd_data, e); end
         end
         @(negedge clk);
      end
      rd_ready = 1'b0;
      n_cmp++; if (q.size() != 0) begin n_err++; $display("FAIL wrap_drain_timeout: left %0d want 0", q.size()); end
   endtask

   task automatic test_stop_when_full();
      q.delete();
      do_clear();
      for (int i = 1; i <= 6; i++) begin
         set_mem(1'b0, 1'b0, 12'(i + 32), 12'(i * 7));
         if (i <= 4) q.push_back({3'd1, 12'(i + 32), 12'(i * 7)});
         @(negedge clk);
      end
      idle();
      n_cmp++; if (d4_count !== 3'd4) begin n_err++; $display("FAIL stop_count: got %0d want 4", d4_count); end
      n_cmp++; if (d4_drop !== 8'd2) begin n_err++; $display("FAIL stop_drop: got %0d want 2", d4_drop); end
      n_cmp++; if (d4_overflow !== 1'b0) begin n_err++; $display("FAIL stop_overflow: got %b want 0", d4_overflow); end
      rd_ready = 1'b1;
      for (int n = 0; n < 16 && q.size() != 0; n++) begin
         if (d4_rd_valid) begin
            e = q.pop_front();
            n_cmp++; if (d4_rd_data !== e) begin n_err++; $display("FAIL stop_record: got %h want %h", d4_rd_data, e); end
         end
         @(negedge clk);
      end
      rd_ready = 1'b0;
      n_cmp++; if (q.size() != 0) begin n_err++; $display("FAIL stop_drain_timeout: left %0d want 0", q.size()); end
   endtask

   task automatic test_full_pop_freeze();
      q.delete();
      do_clear();
      for (int i = 1; i <= 4; i++) begin
         set_mem(1'b0, 1'b1, 12'(i + 100), 12'(i + 200));
         q.push_back({3'd0, 12'(i + 100), 12'(i + 200)});
         @(negedge clk);
      end
      set_mem(1'b0, 1'b1, 12'd105, 12'd205); rd_ready = 1'b1;
      e = q.pop_front();
      n_cmp++; if (w4_rd_data !== e) begin n_err++; $display("FAIL full_pop_head: got %h want %h", w4_rd_data, e); end
      q.push_back({3'd0, 12'd105, 12'd205});
      @(negedge clk);
      idle(); rd_ready = 1'b0;
      n_cmp++; if (w4_count !== 3'd4) begin n_err++; $display("FAIL full_pop_count: got %0d want 4", w4_count); end
      n_cmp++; if (w4_overflow !== 1'b0) begin n_err++; $display("FAIL full_pop_overflow: got %b want 0", w4_overflow); end
      n_cmp++; if (d4_drop !== 8'd0) begin n_err++; $display("FAIL full_pop_drop: got %0d want 0", d4_drop); end
      freeze = 1'b1;
      for (int i = 0; i < 5; i++) begin
         set_mem(1'b1, 1'b0, 12'(i), 12'(i)); set_br(2'd1, 1'b0, 12'(i), 12'(i));
         @(negedge clk);
      end
      idle(); freeze = 1'b0; enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_mem(1'b1, 1'b0, 12'(i), 12'(i));
         @(negedge clk);
      end
      idle(); enable = 1'b1;
      @(negedge clk);
      n_cmp++; if (w4_count !== 3'd4) begin n_err++; $display("FAIL freeze_count: got %0d want 4", w4_count); end
      n_cmp++; if (d4_drop !== 8'd0) begin n_err++; $display("FAIL freeze_drop: got %0d want 0", d4_drop); end
      n_cmp++; if (w4_overflow !== 1'b0) begin n_err++; $display("FAIL freeze_overflow: got %b want 0", w4_overflow); end
      rd_ready = 1'b1;
      for (int n = 0; n < 16 && q.size() != 0; n++) begin
         if (w4_rd_valid) begin
            e = q.pop_front();
            n_cmp++; if (w4_rd_data !== e) begin n_err++; $display("FAIL full_pop_record: got %h want %h", w4_rd_data, e); end
         end
         @(negedge clk);
      end
      rd_ready = 1'b0;
      n_cmp++; if (q.size() != 0) begin n_err++; $display("FAIL full_pop_drain_timeout: left %0d want 0", q.size()); end
   endtask

   task automatic test_drop_saturate();
      do_clear();
      for (int i = 0; i < 304; i++) begin
         set_mem(1'b1, 1'b0, 12'(i), 12'(i));
         @(negedge clk);
      end
      idle();
      n_cmp++; if (d4_drop !== 8'd255) begin n_err++; $display("FAIL sat_drop: got %0d want 255", d4_drop); end
      n_cmp++; if (d4_count !== 3'd4) begin n_err++; $display("FAIL sat_count: got %0d want 4", d4_count); end
      n_cmp++; if (big_overflow !== 1'b1) begin n_err++; $display("FAIL sat_big_overflow: got %b want 1", big_overflow); end
      n_cmp++; if (big_count !== 7'd64) begin n_err++; $display("FAIL sat_big_count: got %0d want 64", big_count); end
      do_clear();
   endtask

   task automatic test_reset_midflight();
      q.delete();
      set_mem(1'b0, 1'b0, 12'o0010, 12'o0020); set_br(2'd1, 1'b0, 12'o0030, 12'o0040);
      @(negedge clk);
      idle();
      #2 reset = 1'b1;
      #1;
      n_cmp++; if (big_rd_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_rd_valid: got %b want 0", big_rd_valid); end
      n_cmp++; if (big_count !== 7'd0) begin n_err++; $display("FAIL mid_rst_count: got %0d want 0", big_count); end
      n_cmp++; if (big_rd_data !== 27'd0) begin n_err++; $display("FAIL mid_rst_rd_data: got %h want 0", big_rd_data); end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      set_mem(1'b0, 1'b1, 12'o0777, 12'o7402);
      q.push_back({3'd0, 12'o0777, 12'o7402});
      @(negedge clk);
      idle();
      @(negedge clk);
      n_cmp++; if (big_count !== 7'd1) begin n_err++; $display("FAIL post_rst_count: got %0d want 1", big_count); end
      rd_ready = 1'b1;
      for (int n = 0; n < 8 && q.size() != 0; n++) begin
         if (big_rd_valid) begin
            e = q.pop_front();
            n_cmp++; if (big_rd_data !== e) begin n_err++; $display("FAIL post_rst_record: got %h want %h", big_rd_data, e); end
         end
         @(negedge clk);
      end
      rd_ready = 1'b0;
      n_cmp++; if (q.size() != 0) begin n_err++; $display("FAIL post_rst_drain_timeout: left %0d want 0", q.size()); end
      n_cmp++; if (big_rd_valid !== 1'b0) begin n_err++; $display("FAIL post_rst_empty: got %b want 0", big_rd_valid); end
   endtask

   initial begin
      test_reset();
      test_capture_order();
      test_back_to_back();
      test_wrap();
      test_stop_when_full();
      test_full_pop_freeze();
      test_drop_saturate();
      test_reset_midflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
